hub_bcm_driver: RTL and testbench
=================================

# hub_bcm_driver

Parametrised HUB-style LED matrix driver for the next generation of panels. It shifts CHANNELS serial data lanes from a shared framebuffer address using binary-coded modulation (BCM). The next bitplane is shifted while the current one is displayed, and each bitplane gets a weighted on-window with global brightness scaling. It sits between the `hdmi_framebuffer` read ports and the GPIO banks, and replaces the single-lane driver for multi-module displays.

## Interface
- DISP_ADDR_WIDTH, 3, row select bits; rows = 2^DISP_ADDR_WIDTH
- DISPLAY_WIDTH, 416, pixels shifted per row per lane
- FB_ADDR_WIDTH, 12, framebuffer address width; must hold rows*DISPLAY_WIDTH-1
- DATA_WIDTH, 8, bits per pixel = number of bitplanes
- CHANNELS, 2, parallel data lanes sharing one address
- BASE_ON, 16, on-window length in clk cycles of plane 0
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- brightness  in  8  global dimming, 0xFF = full
- data_in  in  CHANNELS*DATA_WIDTH  lane c pixel at bits [c*DATA_WIDTH +: DATA_WIDTH]; valid 1 cycle after data_addr
- data_addr  out  FB_ADDR_WIDTH  framebuffer read address
- data_out  out  CHANNELS  serial pixel bit per lane
- clk_out  out  1  panel shift clock
- latch_out  out  1  panel latch strobe
- enable_out  out  1  panel output enable, active-low
- addr_out  out  DISP_ADDR_WIDTH  panel row select
- frame_start  out  1  one-cycle pulse at start of each frame's first shift

## Operation
- Plane order is row-major. For row r = 0..rows-1, planes p = 0..DATA_WIDTH-1 are sent in order. After the last plane of the last row, sequencing wraps to row 0, plane 0.
- Shifter FSM states and transitions:
  - PREFETCH: present data_addr = r*DISPLAY_WIDTH.
  - SHIFT_LO: clk_out=0; data_out[c] <= data_in[c*DATA_WIDTH+p]. Go to SHIFT_HI.
  - SHIFT_HI: clk_out=1; data_addr+1. Go to SHIFT_LO, or to READY after DISPLAY_WIDTH pixels.
  - READY: wait for the window FSM to finish, then go to BLANK.
  - BLANK: enable_out=1.
  - LATCH: latch_out=1, addr_out <= row of the just-shifted plane. Start that plane's window, then go to PREFETCH for the next plane.
- Window: W_p = BASE_ON<<p cycles. enable_out=0 for the first (W_p*b)>>8 cycles, then 1 for the rest, where b = brightness, except b = 256 when brightness = 0xFF. brightness is sampled in the LATCH cycle only.
- Before the first latch after reset, nothing is displayed: enable_out stays 1.
- frame_start pulses in the PREFETCH cycle of row 0, plane 0.
- data_addr wraps to 0 after rows*DISPLAY_WIDTH-1. No out-of-range addresses are issued.

## Timing
- Reset values: clk_out 0, latch_out 0, enable_out 1, data_out 0, addr_out 0, data_addr 0, frame_start 0. Assertion at any point returns all outputs to these values on the next edge. Sequencing then restarts at row 0, plane 0, and no window is open.
- Shift time per plane: S = 1 + 2*DISPLAY_WIDTH cycles. data_in is registered into data_out in SHIFT_LO, one cycle after its address was presented.
- Plane period: max(S+1, W_p) + 2 cycles (READY wait, then BLANK + LATCH).
  - When W_p < S, the plane is shift-limited and enable is off during the extra shift time.
  - When W_p > S, the shifter idles in READY.
- Simultaneous events: when the shift completes in the same cycle the window expires, the design goes directly to BLANK in the next cycle.
- enable_out is always 1 in the BLANK and LATCH cycles. addr_out changes only in LATCH.
- brightness = 0 gives enable_out permanently 1. Shifting and latching continue.

## Structure
- Shared package holds:
  - shifter state encoding (PREFETCH, SHIFT_LO, SHIFT_HI, READY, BLANK, LATCH)
  - window-length constant function BASE_ON<<p
  - width helper clog2 for counter sizing
- Sub-module `hub_bcm_window`:
  - inputs: start pulse, plane index, sampled brightness
  - outputs: enable_out, window_done
  - contains the window counter and the scaled on-length computation
- The top contains the shifter FSM, the address counter, the plane/row counters and the lane muxes.

## Test plan
Bench parameters: DISPLAY_WIDTH=4, DISP_ADDR_WIDTH=1, DATA_WIDTH=2, CHANNELS=2, BASE_ON=16.
- Release reset -> data_addr 0,1,2,3 with 4 clk_out rising edges, then BLANK and a one-cycle latch_out with addr_out=0. enable_out stays 1 throughout.
- data_in lane0=0x1, lane1=0x2 constant -> plane 0 shifts data_out=2'b01 on every edge, plane 1 shifts 2'b10.
- brightness 0xFF -> enable_out low for 16 cycles after the plane 0 latch and 32 after plane 1. Repeat at 0x80 -> 8 and 16. At 0x00 -> never low.
- Run 2 frames -> addr_out latch sequence 0,0,1,1,0,0,1,1. frame_start once per 4 latches. data_addr returns to 0 after 7.
- Pulse reset for 1 cycle mid-SHIFT_HI -> next cycle all outputs at reset values; next shift restarts at data_addr 0 with frame_start.
- Check every latch_out pulse -> enable_out is 1 in that cycle and the cycle before. addr_out is stable outside latch cycles.

Source files
------------

// File: rtl/hub_bcm_driver_pkg.sv
// Shared definitions for the HUB BCM driver: shifter state encoding and sizing helpers.
package hub_bcm_driver_pkg;

    localparam int STATE_W = 3;

    localparam logic [STATE_W-1:0] ST_PREFETCH = 3'd0;
    localparam logic [STATE_W-1:0] ST_SHIFT_LO = 3'd1;
    localparam logic [STATE_W-1:0] ST_SHIFT_HI = 3'd2;
    localparam logic [STATE_W-1:0] ST_READY    = 3'd3;
    localparam logic [STATE_W-1:0] ST_BLANK    = 3'd4;
    localparam logic [STATE_W-1:0] ST_LATCH    = 3'd5;

    // Binary-weighted display window of one bitplane.
    function automatic int unsigned win_len(input int unsigned base_on, input int unsigned plane);
        return base_on << plane;
    endfunction

    function automatic int clog2(input int unsigned value);
        int result = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/hub_bcm_driver_window.sv
// Per-plane on-window timer: counts the weighted window and drives the active-low enable
// for the brightness-scaled leading part of it.
module hub_bcm_window
    import hub_bcm_driver_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int BASE_ON    = 16,
    parameter int PLANE_W    = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [PLANE_W-1:0] plane,
    input  logic [7:0]         brightness,
    output logic               enable_out,
    output logic               window_done
);

    localparam int MAX_WIN = win_len(BASE_ON, DATA_WIDTH - 1);
    localparam int CNT_W   = clog2(MAX_WIN + 1);
    localparam int PROD_W  = CNT_W + 8;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0]  win_table [DATA_WIDTH];
    logic [CNT_W-1:0]  cnt_reg;
    logic [CNT_W-1:0]  len_reg;
    logic [CNT_W-1:0]  on_reg;
    logic              active_reg;
    logic              enable_reg;
    logic [CNT_W-1:0]  len_next;
    logic [CNT_W-1:0]  on_next;
    logic [8:0]        scale;
    logic [PROD_W-1:0] product;
    logic              last;

    for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : g_win
        assign win_table[gi] = CNT_W'(win_len(BASE_ON, gi));
    end

    // Full brightness maps to 256 so that 0xFF lights the whole window.
    assign scale    = (brightness == 8'hFF) ? 9'd256 : {1'b0, brightness};
    assign len_next = win_table[plane];
    assign product  = {{8{1'b0}}, len_next} * {{(PROD_W-9){1'b0}}, scale};
    assign on_next  = CNT_W'(product >> 8);

    assign last        = (cnt_reg == len_reg - CNT_ONE);
    assign window_done = !active_reg || last;
    assign enable_out  = enable_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            active_reg <= 1'b0;
            cnt_reg    <= '0;
            len_reg    <= '0;
            on_reg     <= '0;
            enable_reg <= 1'b1;
        end else if (start) begin
            active_reg <= 1'b1;
            cnt_reg    <= '0;
            len_reg    <= len_next;
            on_reg     <= on_next;
            enable_reg <= (on_next == '0);
        end else if (active_reg) begin
            cnt_reg <= cnt_reg + CNT_ONE;
            if (last) begin
                active_reg <= 1'b0;
                enable_reg <= 1'b1;
            end else begin
                enable_reg <= (cnt_reg + CNT_ONE >= on_reg);
            end
        end
    end

endmodule

// File: rtl/hub_bcm_driver.sv
// Multi-lane HUB panel driver: shifts the next BCM bitplane from the framebuffer while the
// window timer displays the previous one, then blanks and latches.
module hub_bcm_driver
    import hub_bcm_driver_pkg::*;
#(
    parameter int DISP_ADDR_WIDTH = 3,
    parameter int DISPLAY_WIDTH   = 416,
    parameter int FB_ADDR_WIDTH   = 12,
    parameter int DATA_WIDTH      = 8,
    parameter int CHANNELS        = 2,
    parameter int BASE_ON         = 16
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [7:0]                     brightness,
    input  logic [CHANNELS*DATA_WIDTH-1:0] data_in,
    output logic [FB_ADDR_WIDTH-1:0]       data_addr,
    output logic [CHANNELS-1:0]            data_out,
    output logic                           clk_out,
    output logic                           latch_out,
    output logic                           enable_out,
    output logic [DISP_ADDR_WIDTH-1:0]     addr_out,
    output logic                           frame_start
);

    localparam int ROWS    = 1 << DISP_ADDR_WIDTH;
    localparam int PLANE_W = (clog2(DATA_WIDTH) > 0) ? clog2(DATA_WIDTH) : 1;
    localparam int PIX_W   = (clog2(DISPLAY_WIDTH) > 0) ? clog2(DISPLAY_WIDTH) : 1;

    localparam logic [FB_ADDR_WIDTH-1:0]   ADDR_LAST  = FB_ADDR_WIDTH'(ROWS * DISPLAY_WIDTH - 1);
    localparam logic [FB_ADDR_WIDTH-1:0]   ADDR_STEP  = FB_ADDR_WIDTH'(DISPLAY_WIDTH);
    localparam logic [FB_ADDR_WIDTH-1:0]   ADDR_ONE   = FB_ADDR_WIDTH'(1);
    localparam logic [PIX_W-1:0]           PIX_LAST   = PIX_W'(DISPLAY_WIDTH - 1);
    localparam logic [PIX_W-1:0]           PIX_ONE    = PIX_W'(1);
    localparam logic [PLANE_W-1:0]         PLANE_LAST = PLANE_W'(DATA_WIDTH - 1);
    localparam logic [PLANE_W-1:0]         PLANE_ONE  = PLANE_W'(1);
    localparam logic [DISP_ADDR_WIDTH-1:0] ROW_LAST   = DISP_ADDR_WIDTH'(ROWS - 1);
    localparam logic [DISP_ADDR_WIDTH-1:0] ROW_ONE    = DISP_ADDR_WIDTH'(1);

    logic [STATE_W-1:0]         state_reg;
    logic [STATE_W-1:0]         state_next;
    logic                       started_reg;
    logic [DISP_ADDR_WIDTH-1:0] row_reg;
    logic [PLANE_W-1:0]         plane_reg;
    logic [PIX_W-1:0]           pix_reg;
    logic [FB_ADDR_WIDTH-1:0]   row_base_reg;
    logic [FB_ADDR_WIDTH-1:0]   row_base_next;
    logic [FB_ADDR_WIDTH-1:0]   data_addr_reg;
    logic [CHANNELS-1:0]        data_out_reg;
    logic [DISP_ADDR_WIDTH-1:0] addr_out_reg;
    logic [CHANNELS-1:0]        lane_bit;
    logic                       pix_last;
    logic                       plane_last;
    logic                       row_last;
    logic                       window_enable;
    logic                       window_done;

    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_lane
        logic [DATA_WIDTH-1:0] pixel;
        assign pixel        = data_in[gi*DATA_WIDTH +: DATA_WIDTH];
        assign lane_bit[gi] = pixel[plane_reg];
    end

    assign pix_last      = (pix_reg == PIX_LAST);
    assign plane_last    = (plane_reg == PLANE_LAST);
    assign row_last      = (row_reg == ROW_LAST);
    assign row_base_next = row_last ? '0 : row_base_reg + ADDR_STEP;

    // started_reg holds PREFETCH one cycle after reset so frame_start stays low while reset is applied.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_PREFETCH: if (started_reg) state_next = ST_SHIFT_LO;
            ST_SHIFT_LO: state_next = ST_SHIFT_HI;
            ST_SHIFT_HI: state_next = pix_last ? ST_READY : ST_SHIFT_LO;
            ST_READY:    if (window_done) state_next = ST_BLANK;
            ST_BLANK:    state_next = ST_LATCH;
            ST_LATCH:    state_next = ST_PREFETCH;
            default:     state_next = ST_PREFETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= ST_PREFETCH;
            started_reg   <= 1'b0;
            row_reg       <= '0;
            plane_reg     <= '0;
            pix_reg       <= '0;
            row_base_reg  <= '0;
            data_addr_reg <= '0;
            data_out_reg  <= '0;
            addr_out_reg  <= '0;
        end else begin
            state_reg   <= state_next;
            started_reg <= 1'b1;
            case (state_reg)
                ST_SHIFT_LO: begin
                    data_out_reg  <= lane_bit;
                    data_addr_reg <= (data_addr_reg == ADDR_LAST) ? '0 : data_addr_reg + ADDR_ONE;
                end
                ST_SHIFT_HI: pix_reg <= pix_last ? '0 : pix_reg + PIX_ONE;
                ST_BLANK:    addr_out_reg <= row_reg;
                ST_LATCH: begin
                    if (plane_last) begin
                        plane_reg     <= '0;
                        row_reg       <= row_reg + ROW_ONE;
                        row_base_reg  <= row_base_next;
                        data_addr_reg <= row_base_next;
                    end else begin
                        plane_reg     <= plane_reg + PLANE_ONE;
                        data_addr_reg <= row_base_reg;
                    end
                end
                default: ;
            endcase
        end
    end

    hub_bcm_window #(
        .DATA_WIDTH (DATA_WIDTH),
        .BASE_ON    (BASE_ON),
        .PLANE_W    (PLANE_W)
    ) u_window (
        .clk         (clk),
        .reset       (reset),
        .start       (latch_out),
        .plane       (plane_reg),
        .brightness  (brightness),
        .enable_out  (window_enable),
        .window_done (window_done)
    );

    assign data_addr   = data_addr_reg;
    assign data_out    = data_out_reg;
    assign addr_out    = addr_out_reg;
    assign clk_out     = (state_reg == ST_SHIFT_HI);
    assign latch_out   = (state_reg == ST_LATCH);
    assign enable_out  = window_enable || (state_reg == ST_BLANK) || (state_reg == ST_LATCH);
    assign frame_start = (state_reg == ST_PREFETCH) && started_reg && (row_reg == '0) && (plane_reg == '0);

endmodule

// File: tb/tb_hub_bcm_driver.sv
// Directed bench for hub_bcm_driver on a 2-row, 4-pixel, 2-plane, 2-lane panel.
module tb_hub_bcm_driver;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] brightness = 8'hFF;
    logic [3:0] data_in = 4'd0;
    logic [3:0] data_addr;
    logic [1:0] data_out;
    logic       clk_out;
    logic       latch_out;
    logic       enable_out;
    logic [0:0] addr_out;
    logic       frame_start;

    int n_checks = 0;
    int n_errors = 0;
    int mode = 0;

    hub_bcm_driver #(
        .DISP_ADDR_WIDTH (1),
        .DISPLAY_WIDTH   (4),
        .FB_ADDR_WIDTH   (4),
        .DATA_WIDTH      (2),
        .CHANNELS        (2),
        .BASE_ON         (16)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .brightness  (brightness),
        .data_in     (data_in),
        .data_addr   (data_addr),
        .data_out    (data_out),
        .clk_out     (clk_out),
        .latch_out   (latch_out),
        .enable_out  (enable_out),
        .addr_out    (addr_out),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Framebuffer contents: constant lanes in mode 0, address-dependent lanes in mode 1.
    function automatic logic [1:0] pix(input int lane, input int addr);
        if (mode == 0) return (lane == 0) ? 2'd1 : 2'd2;
        return (lane == 0) ? 2'(addr) : 2'(addr * 3 + 1);
    endfunction

    function automatic int exp_low(input int plane, input int b);
        int w;
        int s;
        w = 16 << plane;
        s = (b == 255) ? 256 : b;
        return (w * s) >> 8;
    endfunction

    // One-cycle read latency framebuffer.
    always @(posedge clk) data_in <= {pix(1, int'(data_addr)), pix(0, int'(data_addr))};

    int         latch_cnt = 0;
    int         frame_cnt = 0;
    int         pix_idx = 0;
    int         exp_row = 0;
    int         exp_plane = 0;
    int         low_cnt = 0;
    int         gap = 0;
    int         prev_plane = 0;
    int         prev_b = 0;
    int         mon_addr = 0;
    logic [1:0] p0;
    logic [1:0] p1;
    logic       prev_clk = 1'b0;
    logic       prev_enable = 1'b1;
    logic [3:0] prev_data_addr = 4'd0;
    logic [0:0] prev_addr_out = 1'b0;

    always @(negedge clk) begin
        if (reset) begin
            latch_cnt = 0; frame_cnt = 0; pix_idx = 0; exp_row = 0; exp_plane = 0;
            low_cnt = 0; gap = 0;
            prev_clk = 1'b0; prev_enable = 1'b1; prev_data_addr = 4'd0; prev_addr_out = 1'b0;
        end else begin
            gap++;
            if (!enable_out) low_cnt++;
            check("data_addr_range", int'(data_addr <= 4'd7), 1);
            if (prev_data_addr == 4'd7 && data_addr != 4'd7) check("data_addr_wrap", data_addr, 0);
            if (!latch_out) check("addr_out_stable", addr_out, prev_addr_out);
            if (clk_out && !prev_clk) begin
                mon_addr = exp_row * 4 + pix_idx;
                p0 = pix(0, mon_addr);
                p1 = pix(1, mon_addr);
                check("shift_addr", prev_data_addr, mon_addr);
                check("data_out", data_out, {p1[exp_plane], p0[exp_plane]});
                pix_idx++;
            end
            if (frame_start) begin
                frame_cnt++;
                check("frame_start_addr", data_addr, 0);
                check("frame_start_phase", latch_cnt % 4, 0);
            end
            if (latch_out) begin
                check("latch_enable", enable_out, 1);
                check("latch_enable_prev", prev_enable, 1);
                check("latch_row", addr_out, exp_row);
                check("latch_pixels", pix_idx, 4);
                if (latch_cnt == 0) begin
                    check("dark_before_first_latch", low_cnt, 0);
                end else begin
                    check("window_low_cycles", low_cnt, exp_low(prev_plane, prev_b));
                    check("plane_period", gap, (prev_plane == 0) ? 18 : 34);
                end
                $display("latch %0d row %0d plane %0d brightness %02h low %0d gap %0d",
                         latch_cnt, addr_out, exp_plane, brightness, low_cnt, gap);
                prev_plane = exp_plane;
                prev_b = brightness;
                latch_cnt++;
                low_cnt = 0; gap = 0; pix_idx = 0;
                exp_plane++;
                if (exp_plane == 2) begin
                    exp_plane = 0;
                    exp_row ^= 1;
                end
            end
            prev_clk = clk_out;
            prev_enable = enable_out;
            prev_data_addr = data_addr;
            prev_addr_out = addr_out;
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_clk_out"}, clk_out, 0);
        check({tag, "_latch_out"}, latch_out, 0);
        check({tag, "_enable_out"}, enable_out, 1);
        check({tag, "_data_out"}, data_out, 0);
        check({tag, "_addr_out"}, addr_out, 0);
        check({tag, "_data_addr"}, data_addr, 0);
        check({tag, "_frame_start"}, frame_start, 0);
    endtask

    task automatic wait_latches(input int n);
        int budget;
        budget = 2000;
        while (latch_cnt < n && budget > 0) begin
            @(posedge clk);
            #1;
            budget--;
        end
        if (latch_cnt < n) check("latch_timeout", latch_cnt, n);
    endtask

    initial begin
        int budget;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk);
        #1 reset = 1'b0;

        wait_latches(4);
        check("frames_after_first", frame_cnt, 1);
        brightness = 8'h80;
        mode = 1;
        wait_latches(8);
        brightness = 8'h00;
        mode = 0;
        wait_latches(12);
        brightness = 8'hFF;
        wait_latches(13);
        check("frames_after_three", frame_cnt, 4);

        budget = 50;
        while (!clk_out && budget > 0) begin
            @(posedge clk);
            #1;
            budget--;
        end
        check("reached_shift_hi", clk_out, 1);
        check("window_open_before_reset", enable_out, 0);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check_reset_outputs("mid_reset");

        wait_latches(2);
        check("frames_after_reset", frame_cnt, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
